// File: rtl/datapath_exec_pkg.sv
// rtl/datapath_exec_pkg.sv - shared opcodes, instruction field layout and default widths
package datapath_exec_pkg;

    localparam logic [1:0] OP_NOP      = 2'd0;
    localparam logic [1:0] OP_MEMREAD  = 2'd1;
    localparam logic [1:0] OP_MEMWRITE = 2'd2;
    localparam logic [1:0] OP_DRAW     = 2'd3;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 2;
    localparam int FIELD_BASE = OPCODE_LSB + OPCODE_W;

    localparam int DEF_INSTRUCTION_WIDTH = 32;
    localparam int DEF_RESULT_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH        = 8;
    localparam int DEF_X_COORD_WIDTH     = 8;
    localparam int DEF_Y_COORD_WIDTH     = 7;
    localparam int DEF_COLOUR_WIDTH      = 3;
    localparam int DEF_BLOCK_WIDTH       = 4;
    localparam int DEF_BLOCK_HEIGHT      = 4;
    localparam int COLOUR_BG             = 0;

    // Field offsets for the default widths; fields are packed LSB first above the opcode.
    localparam int MR_ADDR_LSB   = FIELD_BASE;
    localparam int MW_ADDR_LSB   = FIELD_BASE;
    localparam int MW_DATA_LSB   = MW_ADDR_LSB + DEF_ADDR_WIDTH;
    localparam int DR_X_LSB      = FIELD_BASE;
    localparam int DR_Y_LSB      = DR_X_LSB + DEF_X_COORD_WIDTH;
    localparam int DR_COLOUR_LSB = DR_Y_LSB + DEF_Y_COORD_WIDTH;
    localparam int DR_PLOT_LSB   = DR_COLOUR_LSB + DEF_COLOUR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_CAP,
        S_WRITE,
        S_DRAW,
        S_NOP_BUSY
    } state_t;

endpackage

// File: rtl/datapath_exec_block_scan.sv
// rtl/datapath_exec_block_scan.sv - dx-fastest pixel scan over one block with last-pixel flag
module block_scan #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int BLK_W  = 4,
    parameter int BLK_H  = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic [X_W-1:0] px,
    output logic [Y_W-1:0] py,
    output logic           valid,
    output logic           last
);

    localparam int DXW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int DYW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam logic [DXW-1:0] DX_MAX = DXW'(BLK_W - 1);
    localparam logic [DYW-1:0] DY_MAX = DYW'(BLK_H - 1);

    logic           active;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;
    logic [X_W-1:0] bx;
    logic [Y_W-1:0] by;

    // Counters are left at the final pixel so px/py keep showing the last plotted point.
    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            dx     <= '0;
            dy     <= '0;
            bx     <= '0;
            by     <= '0;
        end else if (go) begin
            active <= 1'b1;
            dx     <= '0;
            dy     <= '0;
            bx     <= x;
            by     <= y;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
            end else if (dx == DX_MAX) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

    assign px    = bx + X_W'(dx);
    assign py    = by + Y_W'(dy);
    assign valid = active;
    assign last  = active && (dx == DX_MAX) && (dy == DY_MAX);

endmodule

// File: rtl/datapath_exec.sv
// rtl/datapath_exec.sv - command executor for memory read/write and block drawing
module datapath_exec
    import datapath_exec_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int RESULT_WIDTH      = DEF_RESULT_WIDTH,
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int X_COORD_WIDTH     = DEF_X_COORD_WIDTH,
    parameter int Y_COORD_WIDTH     = DEF_Y_COORD_WIDTH,
    parameter int COLOUR_WIDTH      = DEF_COLOUR_WIDTH,
    parameter int BLOCK_WIDTH       = DEF_BLOCK_WIDTH,
    parameter int BLOCK_HEIGHT      = DEF_BLOCK_HEIGHT,
    parameter int COLOUR_BG         = datapath_exec_pkg::COLOUR_BG
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_dp,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_dp,
    output logic                         finished_dp,
    output logic [RESULT_WIDTH-1:0]      result_dp,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [RESULT_WIDTH-1:0]      mem_wdata,
    output logic                         mem_we,
    input  logic [RESULT_WIDTH-1:0]      mem_rdata,
    output logic [X_COORD_WIDTH-1:0]     vga_x,
    output logic [Y_COORD_WIDTH-1:0]     vga_y,
    output logic [COLOUR_WIDTH-1:0]      vga_colour,
    output logic                         vga_plot
);

    localparam int WR_DATA_LSB = FIELD_BASE + ADDR_WIDTH;
    localparam int Y_LSB       = FIELD_BASE + X_COORD_WIDTH;
    localparam int COLOUR_LSB  = Y_LSB + Y_COORD_WIDTH;
    localparam int PLOT_LSB    = COLOUR_LSB + COLOUR_WIDTH;

    state_t     state, state_next;
    logic       armed;
    logic       accept;
    logic       nop_extra;
    logic       scan_last;
    logic [1:0] opcode;
    logic       unused_instr;

    assign opcode       = instruction_dp[OPCODE_LSB +: OPCODE_W];
    assign accept       = (state == S_IDLE) && start_dp && armed;
    assign unused_instr = ^instruction_dp;

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_MEMREAD:  state_next = S_RD_ADDR;
                        OP_MEMWRITE: state_next = S_WRITE;
                        OP_DRAW:     state_next = S_DRAW;
                        default:     state_next = S_NOP_BUSY;
                    endcase
                end
            end
            S_RD_ADDR:  state_next = S_RD_CAP;
            S_RD_CAP:   state_next = S_IDLE;
            S_WRITE:    state_next = S_NOP_BUSY;
            S_DRAW:     if (scan_last) state_next = S_IDLE;
            S_NOP_BUSY: if (!nop_extra) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Command fields are captured straight from instruction_dp on the accepting edge,
    // so the memory port already carries them during the first busy cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed       <= 1'b0;
            finished_dp <= 1'b1;
            result_dp   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            vga_colour  <= '0;
            nop_extra   <= 1'b0;
        end else begin
            if (!start_dp)   armed <= 1'b1;
            else if (accept) armed <= 1'b0;
            finished_dp <= (state_next == S_IDLE);
            mem_we      <= accept && (opcode == OP_MEMWRITE);
            if (state == S_NOP_BUSY) nop_extra <= 1'b0;
            if (accept) begin
                case (opcode)
                    OP_MEMREAD: mem_addr <= instruction_dp[FIELD_BASE +: ADDR_WIDTH];
                    OP_MEMWRITE: begin
                        mem_addr  <= instruction_dp[FIELD_BASE +: ADDR_WIDTH];
                        mem_wdata <= instruction_dp[WR_DATA_LSB +: RESULT_WIDTH];
                    end
                    OP_DRAW: vga_colour <= instruction_dp[PLOT_LSB]
                                         ? instruction_dp[COLOUR_LSB +: COLOUR_WIDTH]
                                         : COLOUR_WIDTH'(COLOUR_BG);
                    default: nop_extra <= 1'b1;
                endcase
            end
            if (state != S_IDLE && state_next == S_IDLE)
                result_dp <= (state == S_RD_CAP) ? mem_rdata : '0;
        end
    end

    block_scan #(
        .X_W   (X_COORD_WIDTH),
        .Y_W   (Y_COORD_WIDTH),
        .BLK_W (BLOCK_WIDTH),
        .BLK_H (BLOCK_HEIGHT)
    ) u_block_scan (
        .clock (clock),
        .reset (reset),
        .go    (accept && (opcode == OP_DRAW)),
        .x     (instruction_dp[FIELD_BASE +: X_COORD_WIDTH]),
        .y     (instruction_dp[Y_LSB +: Y_COORD_WIDTH]),
        .px    (vga_x),
        .py    (vga_y),
        .valid (vga_plot),
        .last  (scan_last)
    );

endmodule

// File: tb/tb_datapath_exec.sv
// tb/tb_datapath_exec.sv - directed-vector bench for datapath_exec
module tb_datapath_exec;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_dp = 1'b0;
    logic [31:0] instruction_dp = '0;
    logic        finished_dp;
    logic [15:0] result_dp;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    datapath_exec dut (
        .clock          (clock),
        .reset          (reset),
        .start_dp       (start_dp),
        .instruction_dp (instruction_dp),
        .finished_dp    (finished_dp),
        .result_dp      (result_dp),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot)
    );

    logic [15:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = '0;
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int          we_cnt = 0;
    int          cmd_cnt = 0;
    logic [7:0]  we_addr = '0;
    logic [15:0] we_data = '0;
    logic        prev_fin = 1'b1;
    int          px_q[$];
    int          py_q[$];
    int          pc_q[$];

    always @(negedge clock) begin
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        if (vga_plot) begin
            px_q.push_back(int'(vga_x));
            py_q.push_back(int'(vga_y));
            pc_q.push_back(int'(vga_colour));
        end
        if (prev_fin && !finished_dp) cmd_cnt++;
        prev_fin = finished_dp;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Holds start for 'hold' cycles; cyc = cycles after acceptance until finished_dp is seen high.
    task automatic run_cmd(input logic [31:0] instr, input int hold, output int cyc);
        int n;
        bit done;
        n = 0;
        done = 0;
        cyc = -1;
        instruction_dp = instr;
        start_dp = 1'b1;
        while (!(done && n >= hold) && n < 200) begin
            @(negedge clock);
            n++;
            if (n == hold) start_dp = 1'b0;
            if (!done && finished_dp) begin
                done = 1;
                cyc = n;
            end
        end
        start_dp = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [31:0] memwr(input logic [7:0] a, input logic [15:0] d);
        return {6'b0, d, a, 2'b10};
    endfunction

    function automatic logic [31:0] memrd(input logic [7:0] a);
        return {22'b0, a, 2'b01};
    endfunction

    function automatic logic [31:0] draw(input logic [7:0] x, input logic [6:0] y,
                                         input logic [2:0] c, input logic p);
        return {11'b0, p, c, y, x, 2'b11};
    endfunction

    initial begin
        int cyc;
        int c0;
        int w0;
        int n;

        repeat (3) @(negedge clock);
        check("rst_finished", finished_dp, 1);
        check("rst_result", result_dp, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_plot", vga_plot, 0);
        reset = 1'b0;
        @(negedge clock);

        run_cmd(memwr(8'h12, 16'hBEEF), 2, cyc);
        check("wr_cycles", cyc, 3);
        check("wr_we_pulses", we_cnt, 1);
        check("wr_addr", we_addr, 8'h12);
        check("wr_data", we_data, 16'hBEEF);
        check("wr_result", result_dp, 0);

        run_cmd(memrd(8'h12), 2, cyc);
        check("rd_cycles", cyc, 3);
        check("rd_result", result_dp, 16'hBEEF);

        run_cmd(memwr(8'h34, 16'h1234), 1, cyc);
        run_cmd(32'h0000_0000, 1, cyc);
        check("nop_cycles", cyc, 3);
        check("nop_result", result_dp, 0);

        px_q.delete(); py_q.delete(); pc_q.delete();
        run_cmd(draw(8'd10, 7'd20, 3'd5, 1'b1), 1, cyc);
        check("draw1_cycles", cyc, 17);
        check("draw1_count", px_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("draw1_x%0d", k), px_q[k], 10 + k % 4);
            check($sformatf("draw1_y%0d", k), py_q[k], 20 + k / 4);
            check($sformatf("draw1_c%0d", k), pc_q[k], 5);
        end
        check("draw1_hold_x", vga_x, 13);
        check("draw1_hold_y", vga_y, 23);
        check("draw1_plot_off", vga_plot, 0);
        check("draw1_result", result_dp, 0);

        px_q.delete(); py_q.delete(); pc_q.delete();
        run_cmd(draw(8'd254, 7'd126, 3'd7, 1'b0), 1, cyc);
        check("draw2_count", px_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("draw2_x%0d", k), px_q[k], (254 + k % 4) % 256);
            check($sformatf("draw2_y%0d", k), py_q[k], (126 + k / 4) % 128);
            check($sformatf("draw2_c%0d", k), pc_q[k], 0);
        end

        px_q.delete(); py_q.delete(); pc_q.delete();
        c0 = cmd_cnt;
        run_cmd(draw(8'd0, 7'd0, 3'd3, 1'b1), 40, cyc);
        check("hold40_cycles", cyc, 17);
        check("hold40_cmds", cmd_cnt - c0, 1);
        check("hold40_pixels", px_q.size(), 16);
        run_cmd(memrd(8'h34), 1, cyc);
        check("after_hold_rd", result_dp, 16'h1234);

        c0 = cmd_cnt;
        w0 = we_cnt;
        run_cmd(memrd(8'h12), 2, cyc);
        check("b2b_rd1", result_dp, 16'hBEEF);
        run_cmd(memrd(8'h34), 2, cyc);
        check("b2b_rd2", result_dp, 16'h1234);
        check("b2b_cmds", cmd_cnt - c0, 2);
        check("b2b_no_we", we_cnt - w0, 0);

        px_q.delete(); py_q.delete(); pc_q.delete();
        instruction_dp = draw(8'd40, 7'd40, 3'd2, 1'b1);
        start_dp = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 7; i++) begin
            @(negedge clock);
            if (vga_plot) n++;
        end
        check("abort_reached_px7", n, 7);
        reset = 1'b1;
        start_dp = 1'b0;
        @(negedge clock);
        check("abort_plot", vga_plot, 0);
        check("abort_finished", finished_dp, 1);
        check("abort_vga_x", vga_x, 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("abort_pixels", px_q.size(), 7);
        run_cmd(memrd(8'h12), 1, cyc);
        check("post_abort_rd", result_dp, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_exec.md
DATAPATH_EXEC -- requirements
Module: datapath_exec

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- INSTRUCTION_WIDTH, 32, command word width.
- RESULT_WIDTH, 16, result and memory data width.
- ADDR_WIDTH, 8, memory word address width.
- X_COORD_WIDTH, 8, screen x width.
- Y_COORD_WIDTH, 7, screen y width.
- COLOUR_WIDTH, 3, pixel colour width.
- BLOCK_WIDTH, 4, drawn block width in pixels.
- BLOCK_HEIGHT, 4, drawn block height in pixels.
- COLOUR_BG, 0, erase colour.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start_dp, in, 1, command request from the client FSM.
- instruction_dp, in, INSTRUCTION_WIDTH, command word.
- finished_dp, out, 1, high when idle or done.
- result_dp, out, RESULT_WIDTH, command result.
- mem_addr, out, ADDR_WIDTH, RAM address.
- mem_wdata, out, RESULT_WIDTH, RAM write data.
- mem_we, out, 1, RAM write enable.
- mem_rdata, in, RESULT_WIDTH, RAM read data; synchronous RAM, 1-cycle latency.
- vga_x, out, X_COORD_WIDTH, pixel x.
- vga_y, out, Y_COORD_WIDTH, pixel y.
- vga_colour, out, COLOUR_WIDTH, pixel colour.
- vga_plot, out, 1, pixel write strobe.

Function
REQ-003 Opcode is instruction[1:0]: 0 NOP, 1 MEMREAD, 2 MEMWRITE, 3 DRAW.
REQ-004 Fields above the opcode, LSB first:
- MEMREAD: {addr}.
- MEMWRITE: {data, addr}.
- DRAW: {plot, colour, y, x}.
- Unused upper bits are ignored.
REQ-005 The state machine has states IDLE, RD_ADDR, RD_CAP, WRITE, DRAW and NOP_BUSY; finished_dp is registered and equals 1 only in IDLE.
REQ-006 A command is accepted in IDLE when start_dp=1 and the internal flag armed=1.
- The full instruction is latched on acceptance.
- armed clears on acceptance and sets on any cycle start_dp is sampled 0.
- A start_dp held high for two cycles therefore yields exactly one command.
REQ-007 With acceptance at edge T, finished_dp=0 from T+1 until the edge that returns to IDLE.
REQ-008 MEMREAD timing:
- mem_addr=addr during T+1.
- mem_rdata is captured at edge T+2.
- result_dp=mem_rdata and finished_dp=1 from T+3.
REQ-009 MEMWRITE: mem_addr=addr, mem_wdata=data and mem_we=1 during exactly cycle T+1; result_dp=0 and finished_dp=1 from T+3, passing through one WRITE cycle and one NOP_BUSY cycle.
REQ-010 NOP: result_dp=0 and finished_dp=1 from T+3, passing through two NOP_BUSY cycles; the minimum busy time is 2 cycles for every opcode.
REQ-011 DRAW emits BLOCK_WIDTH*BLOCK_HEIGHT pixels, one per cycle, from T+1:
- Pixel k has vga_x=x+(k mod BLOCK_WIDTH) and vga_y=y+(k div BLOCK_WIDTH); dx runs fastest.
- vga_plot=1 on each pixel cycle.
- vga_colour=colour if plot=1, else COLOUR_BG.
- result_dp=0.
- finished_dp=1 the cycle after the last pixel; with the defaults that is T+17.
REQ-012 Coordinate addition truncates to the port width, so blocks wrap modulo 2^width with no clipping.
REQ-013 Outside their active cycles, mem_we=0 and vga_plot=0. mem_addr, mem_wdata, vga_x, vga_y and vga_colour hold their last values.
REQ-014 result_dp holds its value from completion until the next completion.
REQ-015 start_dp is ignored in every non-IDLE state.
REQ-016 A start_dp that rises in the same cycle the FSM returns to IDLE is accepted on the next edge only if armed=1.

Reset
REQ-017 When reset=1 at an edge:
- State goes to IDLE and any DRAW or memory operation is aborted with no further strobes.
- finished_dp=1 and armed=0.
- result_dp, mem_addr, mem_wdata, vga_x, vga_y and vga_colour are 0.
- mem_we=0 and vga_plot=0.
REQ-018 After reset, the first command needs start_dp to be sampled low at least once.

Structure
REQ-019 A shared package holds:
- the opcode constants;
- the field offset/width constants for each instruction format;
- the COLOUR_BG and default width constants used by the ant FSMs.
REQ-020 The pixel dx/dy counter with its last-pixel flag is one sub-module, block_scan, with ports clock, reset, go, x, y, px, py, valid and last.

Verification
REQ-021 Write then read:
- MEMWRITE addr=0x12, data=0xBEEF with start held 2 cycles: one mem_we pulse and finished_dp=1 at T+3.
- Then MEMREAD addr=0x12: result_dp=0xBEEF and finished_dp=1 at T+3.
REQ-022 DRAW x=10, y=20, colour=5, plot=1: exactly 16 vga_plot cycles covering x 10..13 and y 20..23 in dx-fastest order with colour 5; finished_dp=1 at T+17.
REQ-023 DRAW x=254, y=126, plot=0: vga_x wraps 254,255,0,1 and vga_y wraps 126,127,0,1; colour is 0.
REQ-024 start_dp held high for 40 cycles during a DRAW: exactly one command executes; the next start is accepted only after start_dp goes low.
REQ-025 reset asserted at pixel 7 of a DRAW: vga_plot=0 and finished_dp=1 on the following cycle, and no more pixels are emitted.
REQ-026 Back-to-back MEMREADs driven by the ant-draw 2-cycle-start protocol: both results are correct, and there is no dropped or duplicated command.
